// File: rtl/wb_arb_mux.sv
// wb_arb_mux: N-to-1 registered mux/arbiter (explicit, fixed-priority or round-robin) with valid/ready.
// Define MUX_SKID_EN to add a 1-entry skid register; then in_ready no longer depends on out_ready.
module wb_arb_mux #(
    parameter  int N    = 4,
    parameter  int W    = 32,
    parameter  int MODE = 2,
    localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [SELW-1:0] sel,
    input  logic [N-1:0]    in_valid,
    input  logic [N*W-1:0]  in_data,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    output logic [SELW-1:0] out_src,
    input  logic            out_ready
);

    logic            r_out_valid;
    logic [W-1:0]    r_out_data;
    logic [SELW-1:0] r_out_src;
    logic [SELW-1:0] r_rr_ptr;

    logic            w_any;
    logic [SELW-1:0] w_idx;
    logic [W-1:0]    w_word;
    logic            w_load_ok;
    logic            w_accept;

    // Candidate order: ascending from 0, or from r_rr_ptr with wrap in round-robin mode.
    // MODE 0 only admits the candidate equal to sel, so sel >= N never matches.
    always_comb begin : grant_c
        int j;
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_any = 1'b0;
        w_idx = '0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            if (MODE == 2) begin
                j = int'(r_rr_ptr) + k;
                if (j >= N) j = j - N;
            end else begin
                j = k;
            end
            if (!w_any && in_valid[j] && (MODE != 0 || sel == SELW'(j))) begin
                w_any = 1'b1;
                w_idx = SELW'(j);
            end
        end
    end

    always_comb begin : word_c
        w_word = '0;
        for (int i = 0; i < N; i++) begin
            if (w_idx == SELW'(i)) w_word = in_data[i*W +: W];
        end
    end

    always_comb begin : ready_c
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = w_any && (w_idx == SELW'(i)) && w_load_ok && !reset;
        end
    end

    assign w_accept = |in_ready;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_rr_ptr <= (w_idx == SELW'(N-1)) ? '0 : w_idx + 1'b1;
        end
    end

`ifdef MUX_SKID_EN
    logic            r_skid_full;
    logic [W-1:0]    r_skid_data;
    logic [SELW-1:0] r_skid_src;

    assign w_load_ok = !r_skid_full;

    // The skid only fills while the output register is stalled, so skid full implies out_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_skid_full <= 1'b0;
            r_skid_data <= '0;
            r_skid_src  <= '0;
        end else if (r_skid_full) begin
            if (out_ready) begin
                r_out_data  <= r_skid_data;
                r_out_src   <= r_skid_src;
                r_skid_full <= 1'b0;
            end
        end else if (w_accept) begin
            if (r_out_valid && !out_ready) begin
                r_skid_data <= w_word;
                r_skid_src  <= w_idx;
                r_skid_full <= 1'b1;
            end else begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_word;
                r_out_src   <= w_idx;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
`else
    assign w_load_ok = !r_out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
        end else if (w_load_ok) begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_out_data <= w_word;
                r_out_src  <= w_idx;
            end
        end
    end
`endif

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

endmodule

// File: tb/tb_wb_arb_mux.sv
// Directed bench for wb_arb_mux: one instance per selection mode, shared clock and reset.
module tb_wb_arb_mux;

    logic clk;
    logic reset;

    logic [1:0]   rr_sel, fp_sel, ea_sel;
    logic [3:0]   rr_valid, fp_valid, ea_valid;
    logic [127:0] rr_data, fp_data, ea_data;
    logic [3:0]   rr_ready, fp_ready, ea_ready;
    logic         rr_ov, fp_ov, ea_ov;
    logic [31:0]  rr_od, fp_od, ea_od;
    logic [1:0]   rr_os, fp_os, ea_os;
    logic         rr_or, fp_or, ea_or;

    int n_checks;
    int n_errors;
    logic [3:0] exp_r;

    wb_arb_mux #(.N(4), .W(32), .MODE(2)) u_rr (
        .clk(clk), .reset(reset), .sel(rr_sel), .in_valid(rr_valid), .in_data(rr_data),
        .in_ready(rr_ready), .out_valid(rr_ov), .out_data(rr_od), .out_src(rr_os), .out_ready(rr_or)
    );

    wb_arb_mux #(.N(4), .W(32), .MODE(1)) u_fp (
        .clk(clk), .reset(reset), .sel(fp_sel), .in_valid(fp_valid), .in_data(fp_data),
        .in_ready(fp_ready), .out_valid(fp_ov), .out_data(fp_od), .out_src(fp_os), .out_ready(fp_or)
    );

    wb_arb_mux #(.N(4), .W(32), .MODE(0)) u_ea (
        .clk(clk), .reset(reset), .sel(ea_sel), .in_valid(ea_valid), .in_data(ea_data),
        .in_ready(ea_ready), .out_valid(ea_ov), .out_data(ea_od), .out_src(ea_os), .out_ready(ea_or)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of run, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        rr_sel = 2'd0; fp_sel = 2'd0; ea_sel = 2'd0;
        rr_valid = 4'b1111; fp_valid = 4'b1111; ea_valid = 4'b1111;
        rr_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        fp_data = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        ea_data = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
        rr_or = 1'b1; fp_or = 1'b1; ea_or = 1'b1;

        // Reset held two cycles with every channel valid.
        tick();
        tick();
        check("rst_out_valid", 64'(rr_ov), 64'd0);
        check("rst_out_data", 64'(rr_od), 64'd0);
        check("rst_out_src", 64'(rr_os), 64'd0);
        check("rst_in_ready_rr", 64'(rr_ready), 64'd0);
        check("rst_in_ready_fp", 64'(fp_ready), 64'd0);
        check("rst_in_ready_ea", 64'(ea_ready), 64'd0);

        // Round-robin over four always-valid channels.
        reset = 1'b0;
        fp_valid = 4'b0000;
        ea_valid = 4'b0000;
        #1;
        for (int k = 0; k < 8; k++) begin
            exp_r = 4'b0001 << (k % 4);
            check("rr_in_ready", 64'(rr_ready), 64'(exp_r));
            tick();
            check("rr_out_valid", 64'(rr_ov), 64'd1);
            check("rr_out_src", 64'(rr_os), 64'(k % 4));
            check("rr_out_data", 64'(rr_od), 64'(32'hA0 + (k % 4)));
        end
        rr_valid = 4'b0000;
        tick();
        check("rr_drain_valid", 64'(rr_ov), 64'd0);
        check("rr_drain_data_kept", 64'(rr_od), 64'hA3);
        check("rr_drain_src_kept", 64'(rr_os), 64'd3);

        // Fixed priority: lowest valid index wins.
        fp_valid = 4'b1010;
        #1;
        check("fp_ready_1010", 64'(fp_ready), 64'b0010);
        tick();
        check("fp_src_1", 64'(fp_os), 64'd1);
        check("fp_data_1", 64'(fp_od), 64'hB1);
        fp_valid = 4'b1000;
        #1;
        check("fp_ready_1000", 64'(fp_ready), 64'b1000);
        tick();
        check("fp_src_3", 64'(fp_os), 64'd3);
        check("fp_data_3", 64'(fp_od), 64'hB3);
        fp_valid = 4'b0000;
        tick();
        check("fp_drain_valid", 64'(fp_ov), 64'd0);

        // Explicit address.
        ea_sel = 2'd2;
        ea_valid = 4'b0100;
        #1;
        check("ea_ready_sel2", 64'(ea_ready), 64'b0100);
        tick();
        check("ea_valid_sel2", 64'(ea_ov), 64'd1);
        check("ea_src_sel2", 64'(ea_os), 64'd2);
        check("ea_data_sel2", 64'(ea_od), 64'hC2);
        ea_valid = 4'b0001;
        #1;
        check("ea_ready_unsel", 64'(ea_ready), 64'b0000);
        tick();
        check("ea_drain_valid", 64'(ea_ov), 64'd0);
        check("ea_drain_data_kept", 64'(ea_od), 64'hC2);

        // Backpressure on the round-robin instance (pointer is back at 0).
        rr_data[31:0] = 32'hDEADBEEF;
        rr_valid = 4'b0001;
        #1;
        check("bp_ready_ch0", 64'(rr_ready), 64'b0001);
        tick();
        check("bp_first_data", 64'(rr_od), 64'hDEADBEEF);
        rr_or = 1'b0;
        rr_data[63:32] = 32'h12345678;
        rr_valid = 4'b0010;
`ifdef MUX_SKID_EN
        #1;
        check("bp_skid_accept", 64'(rr_ready), 64'b0010);
        tick();
        check("bp_hold_data", 64'(rr_od), 64'hDEADBEEF);
        check("bp_hold_src", 64'(rr_os), 64'd0);
        rr_data[95:64] = 32'h00000055;
        rr_valid = 4'b0100;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("bp_skid_stall_ready", 64'(rr_ready), 64'd0);
            tick();
            check("bp_hold_valid", 64'(rr_ov), 64'd1);
            check("bp_hold_data", 64'(rr_od), 64'hDEADBEEF);
        end
        rr_or = 1'b1;
        #1;
        check("bp_skid_drain_ready", 64'(rr_ready), 64'd0);
        tick();
        check("bp_second_src", 64'(rr_os), 64'd1);
        check("bp_second_data", 64'(rr_od), 64'h12345678);
        #1;
        check("bp_third_ready", 64'(rr_ready), 64'b0100);
        tick();
        check("bp_third_src", 64'(rr_os), 64'd2);
        check("bp_third_data", 64'(rr_od), 64'h55);
        rr_valid = 4'b0000;
        tick();
        check("bp_final_valid", 64'(rr_ov), 64'd0);
`else
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_stall_ready", 64'(rr_ready), 64'd0);
            tick();
            check("bp_hold_valid", 64'(rr_ov), 64'd1);
            check("bp_hold_data", 64'(rr_od), 64'hDEADBEEF);
            check("bp_hold_src", 64'(rr_os), 64'd0);
        end
        rr_or = 1'b1;
        #1;
        check("bp_release_ready", 64'(rr_ready), 64'b0010);
        tick();
        check("bp_second_valid", 64'(rr_ov), 64'd1);
        check("bp_second_src", 64'(rr_os), 64'd1);
        check("bp_second_data", 64'(rr_od), 64'h12345678);
        rr_valid = 4'b0000;
        tick();
        check("bp_final_valid", 64'(rr_ov), 64'd0);
`endif

        // Reset while the output is stalled; pointer was moved to 2 by the ch1 grant.
        rr_data[63:32] = 32'h00000077;
        rr_valid = 4'b0010;
        #1;
        check("rst6_ready_ch1", 64'(rr_ready), 64'b0010);
        tick();
        check("rst6_loaded", 64'(rr_od), 64'h77);
        rr_or = 1'b0;
        rr_valid = 4'b0000;
        reset = 1'b1;
        tick();
        check("rst6_out_valid", 64'(rr_ov), 64'd0);
        check("rst6_out_data", 64'(rr_od), 64'd0);
        check("rst6_rr_ptr", 64'(u_rr.r_rr_ptr), 64'd0);
        reset = 1'b0;
        rr_or = 1'b1;
        rr_valid = 4'b1001;
        #1;
        check("rst6_grant_from_0", 64'(rr_ready), 64'b0001);
        tick();
        check("rst6_after_src", 64'(rr_os), 64'd0);
        rr_valid = 4'b0000;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
